pic_sched: RTL and testbench
============================

PIC_SCHED -- requirements
Module: pic_sched

Interface
REQ-001 SHALL have parameter IDX_W, default 16, index width driven to the compare unit.
REQ-002 SHALL have parameter LEN_W, default 8, width of list lengths and addresses.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, depth of the downstream match FIFO.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk  in  1  clock; rst_n  in  1  async reset, active low.
REQ-005 SHALL have port start  in  1  pulse, begin merge of two sorted index lists.
REQ-006 SHALL have port a_len, b_len  in  LEN_W  number of nonzeros in lists A and B.
REQ-007 SHALL have port a_addr, b_addr  out  LEN_W  read pointers into the index RAMs.
REQ-008 SHALL have port a_idx, b_idx  in  IDX_W  RAM data, valid one cycle after the address.
REQ-009 SHALL have port cmp_a, cmp_b  out  IDX_W  registered indices to the compare unit.
REQ-010 SHALL have port pic_write  out  1  FIFO write enable, registered and aligned with cmp_a/cmp_b.
REQ-011 SHALL have port fpu_ready  in  1  consumer can take one FIFO entry.
REQ-012 SHALL have port pic_read  out  1  FIFO read enable to the consumer.
REQ-013 SHALL have ports busy  out  1 and done  out  1, where done is a one-cycle pulse at end of merge.
REQ-014 SHALL have port match_cnt  out  LEN_W+1  number of matches written in the current merge.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, CMP and DONE; busy SHALL be high in every state except IDLE.
REQ-016 IDLE: on start, SHALL latch a_len/b_len, clear pointers and match_cnt, then go to FETCH; if either length is 0, SHALL go to DONE instead.
REQ-017 FETCH: SHALL drive a_addr/b_addr from the pointers and go to CMP next cycle.
REQ-018 CMP, a_idx<b_idx: SHALL increment the A pointer. CMP, a_idx>b_idx: SHALL increment the B pointer. Neither case writes.
REQ-019 CMP, a_idx==b_idx, FIFO not full: SHALL register cmp_a/cmp_b, assert pic_write for exactly one cycle, increment both pointers and increment match_cnt.
REQ-020 CMP, a_idx==b_idx, occupancy==FIFO_DEPTH: SHALL stay in CMP with pic_write=0 until a read frees a slot.
REQ-021 After CMP, SHALL go to DONE when either incremented pointer equals its latched length, otherwise to FETCH; each comparison therefore costs 2 cycles.
REQ-022 DONE: SHALL assert done for one cycle, then return to IDLE; match_cnt SHALL hold its value until the next start.
REQ-023 SHALL track FIFO occupancy with a counter of width $clog2(FIFO_DEPTH+1): +1 on write only, -1 on read only, unchanged when both occur.
REQ-024 pic_read SHALL equal fpu_ready AND (occupancy!=0), combinationally, in every state including IDLE, so the FIFO drains after done.
REQ-025 start SHALL be ignored while busy.
REQ-026 Pointers SHALL never exceed their latched length; a wrap of the LEN_W counters SHALL be impossible.

Reset
REQ-027 On rst_n low, at any time including mid-merge, SHALL enter IDLE and zero pointers, occupancy, match_cnt, cmp_a, cmp_b, pic_write, done and busy.

Configuration
REQ-028 With PIC_SCHED_STATS_EN defined, SHALL add outputs cyc_cnt (32 bits, cycles spent busy) and stall_cnt (32 bits, cycles held in CMP because the FIFO was full); both SHALL clear on start and on reset.
REQ-029 Without PIC_SCHED_STATS_EN, these ports and counters SHALL be absent.

Structure
REQ-030 The state enum typedef and the default width constants SHALL live in shared package pic_pkg.
REQ-031 The occupancy counter SHALL be a sub-module pic_occ_cnt; the FSM SHALL stay in pic_sched.

Verification
REQ-032 A={1,4,7,9}, B={2,4,9}, fpu_ready=1 -> two pic_write pulses with cmp_a=4, then 9; match_cnt=2; done asserted.
REQ-033 a_len=0, b_len=5, start -> done pulses 1 cycle after start; no pic_write; addresses never advance.
REQ-034 FIFO_DEPTH=2, lists identical, length 5, fpu_ready=0 -> exactly 2 writes, FSM held in CMP; raising fpu_ready resumes merging to match_cnt=5.
REQ-035 Write and read in the same cycle with occupancy=1 -> occupancy stays at 1; pic_read never asserts while occupancy=0.
REQ-036 rst_n pulsed low mid-merge -> all outputs zero immediately; a new start then runs a full merge correctly.
REQ-037 start pulsed while busy -> ignored; the in-flight match_cnt and pointers are unaffected.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared definitions for the sparse-index merge scheduler: FSM state type and default widths.
package pic_pkg;

  localparam int IDX_W_DEF      = 16;
  localparam int LEN_W_DEF      = 8;
  localparam int FIFO_DEPTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_CMP   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/pic_occ_cnt.sv
// Occupancy tracker for the downstream match FIFO; a simultaneous write and read leave the count unchanged.
module pic_occ_cnt #(
  parameter int DEPTH = 16,
  parameter int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic             rd,
  output logic [OCC_W-1:0] occ,
  output logic             full,
  output logic             empty
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ <= '0;
    end else if (wr && !rd) begin
      occ <= occ + 1'b1;
    end else if (rd && !wr) begin
      occ <= occ - 1'b1;
    end
  end

  assign full  = (occ == OCC_W'(DEPTH));
  assign empty = (occ == '0);

endmodule

// File: rtl/pic_sched.sv
// Merge scheduler: walks two sorted index lists and writes matching index pairs to a FIFO.
// Optional busy/stall statistics counters are enabled with PIC_SCHED_STATS_EN.
module pic_sched
  import pic_pkg::*;
#(
  parameter int IDX_W      = IDX_W_DEF,
  parameter int LEN_W      = LEN_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] a_len,
  input  logic [LEN_W-1:0] b_len,
  output logic [LEN_W-1:0] a_addr,
  output logic [LEN_W-1:0] b_addr,
  input  logic [IDX_W-1:0] a_idx,
  input  logic [IDX_W-1:0] b_idx,
  output logic [IDX_W-1:0] cmp_a,
  output logic [IDX_W-1:0] cmp_b,
  output logic             pic_write,
  input  logic             fpu_ready,
  output logic             pic_read,
  output logic             busy,
  output logic             done,
  output logic [LEN_W:0]   match_cnt,
  output state_t           dbg_state
`ifdef PIC_SCHED_STATS_EN
  ,
  output logic [31:0]      cyc_cnt,
  output logic [31:0]      stall_cnt
`endif
);

  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  state_t           state;
  logic [LEN_W-1:0] a_ptr, b_ptr, a_lat, b_lat;
  logic [LEN_W-1:0] a_nxt, b_nxt;
  logic [OCC_W-1:0] occ;
  logic             fifo_full, fifo_empty;
  logic             is_eq, is_lt, stall, finish;

  pic_occ_cnt #(.DEPTH(FIFO_DEPTH), .OCC_W(OCC_W)) u_occ (
    .clk  (clk),
    .rst_n(rst_n),
    .wr   (pic_write),
    .rd   (pic_read),
    .occ  (occ),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // RAM data is valid in CMP because the address has been stable since FETCH.
  always_comb begin
    is_eq  = (a_idx == b_idx);
    is_lt  = (a_idx < b_idx);
    stall  = (state == ST_CMP) && is_eq && fifo_full;
    a_nxt  = a_ptr + LEN_W'(is_lt || is_eq);
    b_nxt  = b_ptr + LEN_W'(!is_lt);
    finish = (a_nxt == a_lat) || (b_nxt == b_lat);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      a_ptr     <= '0;
      b_ptr     <= '0;
      a_lat     <= '0;
      b_lat     <= '0;
      cmp_a     <= '0;
      cmp_b     <= '0;
      pic_write <= 1'b0;
      match_cnt <= '0;
    end else begin
      pic_write <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_lat     <= a_len;
            b_lat     <= b_len;
            a_ptr     <= '0;
            b_ptr     <= '0;
            match_cnt <= '0;
            state     <= (a_len == '0 || b_len == '0) ? ST_DONE : ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_CMP;
        ST_CMP: begin
          if (!stall) begin
            a_ptr <= a_nxt;
            b_ptr <= b_nxt;
            if (is_eq) begin
              cmp_a     <= a_idx;
              cmp_b     <= b_idx;
              pic_write <= 1'b1;
              match_cnt <= match_cnt + 1'b1;
            end
            state <= finish ? ST_DONE : ST_FETCH;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign a_addr    = a_ptr;
  assign b_addr    = b_ptr;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign pic_read  = fpu_ready && !fifo_empty;
  assign dbg_state = state;

`ifdef PIC_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt   <= '0;
      stall_cnt <= '0;
    end else if (state == ST_IDLE && start) begin
      cyc_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (busy)  cyc_cnt   <= cyc_cnt + 32'd1;
      if (stall) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pic_sched.sv
// Bench for pic_sched: RAM model, set-intersection reference, scoreboard and FIFO occupancy model.
module tb_pic_sched;
  import pic_pkg::*;

  localparam int IDX_W = 16;
  localparam int LEN_W = 8;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             fpu_ready = 1'b0;
  logic [LEN_W-1:0] a_len = '0, b_len = '0;
  logic [LEN_W-1:0] a_addr, b_addr;
  logic [IDX_W-1:0] a_idx = '0, b_idx = '0;
  logic [IDX_W-1:0] cmp_a, cmp_b;
  logic             pic_write, pic_read, busy, done;
  logic [LEN_W:0]   match_cnt;
  state_t           dbg_state;
`ifdef PIC_SCHED_STATS_EN
  logic [31:0]      cyc_cnt, stall_cnt;
`endif

  logic [IDX_W-1:0]   a_mem [256];
  logic [IDX_W-1:0]   b_mem [256];
  logic [2*IDX_W-1:0] exp_q [$];
  logic [LEN_W:0]     cnt_q [$];

  int vectors = 0;
  int miscompares = 0;
  int occ_m = 0;
  int wr_total = 0;
  int cur_alen = 0, cur_blen = 0;
  int ready_mode = 0;

  pic_sched #(.IDX_W(IDX_W), .LEN_W(LEN_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a_len    (a_len),
    .b_len    (b_len),
    .a_addr   (a_addr),
    .b_addr   (b_addr),
    .a_idx    (a_idx),
    .b_idx    (b_idx),
    .cmp_a    (cmp_a),
    .cmp_b    (cmp_b),
    .pic_write(pic_write),
    .fpu_ready(fpu_ready),
    .pic_read (pic_read),
    .busy     (busy),
    .done     (done),
    .match_cnt(match_cnt),
    .dbg_state(dbg_state)
`ifdef PIC_SCHED_STATS_EN
    ,
    .cyc_cnt  (cyc_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  // clock / reset-independent infrastructure
  initial forever #5 clk = ~clk;

  always @(posedge clk) begin
    a_idx <= a_mem[a_addr];
    b_idx <= b_mem[b_addr];
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       fpu_ready = 1'b0;
      1:       fpu_ready = 1'b1;
      default: fpu_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      chk("pic_read", longint'(pic_read), longint'(fpu_ready && occ_m != 0));
      if (busy) begin
        chk("a_ptr_bound", longint'(int'(a_addr) <= cur_alen), 1);
        chk("b_ptr_bound", longint'(int'(b_addr) <= cur_blen), 1);
      end
      if (pic_write) begin
        logic [2*IDX_W-1:0] e;
        wr_total++;
        chk("write_room", longint'(occ_m < DEPTH), 1);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL spurious_write: got cmp_a=%0h expected no write", cmp_a);
        end else begin
          e = exp_q.pop_front();
          chk("cmp_a", longint'(cmp_a), longint'(e[2*IDX_W-1:IDX_W]));
          chk("cmp_b", longint'(cmp_b), longint'(e[IDX_W-1:0]));
        end
      end
      if (done) begin
        if (cnt_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL spurious_done: got done=1 expected 0 at %0t", $time);
        end else begin
          chk("match_cnt", longint'(match_cnt), longint'(cnt_q.pop_front()));
          chk("no_pending_writes", longint'(exp_q.size()), 0);
        end
      end
      occ_m = occ_m + int'(pic_write) - int'(pic_read);
    end
  end

  // driver tasks
  task automatic load_rand(input int alen, input int blen, input int step_max);
    int v;
    v = $urandom_range(0, 3);
    for (int i = 0; i < alen; i++) begin
      a_mem[i] = IDX_W'(v);
      v += $urandom_range(1, step_max);
    end
    v = $urandom_range(0, 3);
    for (int j = 0; j < blen; j++) begin
      b_mem[j] = IDX_W'(v);
      v += $urandom_range(1, step_max);
    end
  endtask

  // Reference: the matches are the common elements of two strictly increasing sets, in ascending order.
  task automatic push_expect(input int alen, input int blen);
    int n;
    n = 0;
    if (alen > 0 && blen > 0) begin
      for (int i = 0; i < alen; i++)
        for (int j = 0; j < blen; j++)
          if (a_mem[i] == b_mem[j]) begin
            exp_q.push_back({a_mem[i], b_mem[j]});
            n++;
          end
    end
    cnt_q.push_back((LEN_W+1)'(n));
  endtask

  task automatic start_merge(input int alen, input int blen);
    cur_alen = alen;
    cur_blen = blen;
    a_len = LEN_W'(alen);
    b_len = LEN_W'(blen);
    push_expect(alen, blen);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", cyc);
      exp_q.delete();
      cnt_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, longint'(busy), 0);
    chk({tag, "_done"}, longint'(done), 0);
    chk({tag, "_pic_write"}, longint'(pic_write), 0);
    chk({tag, "_pic_read"}, longint'(pic_read), 0);
    chk({tag, "_match_cnt"}, longint'(match_cnt), 0);
    chk({tag, "_cmp_a"}, longint'(cmp_a), 0);
    chk({tag, "_cmp_b"}, longint'(cmp_b), 0);
    chk({tag, "_a_addr"}, longint'(a_addr), 0);
    chk({tag, "_b_addr"}, longint'(b_addr), 0);
    chk({tag, "_state"}, longint'(dbg_state), longint'(ST_IDLE));
  endtask

  initial begin
    int cyc, w0, alen, blen;
    for (int i = 0; i < 256; i++) begin
      a_mem[i] = '0;
      b_mem[i] = '0;
    end
    #2;
    chk_zero_outputs("reset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // basic example: A={1,4,7,9}, B={2,4,9}
    ready_mode = 1;
    a_mem[0] = 16'd1; a_mem[1] = 16'd4; a_mem[2] = 16'd7; a_mem[3] = 16'd9;
    b_mem[0] = 16'd2; b_mem[1] = 16'd4; b_mem[2] = 16'd9;
    w0 = wr_total;
    start_merge(4, 3);
    wait_done(cyc);
    chk("example_writes", longint'(wr_total - w0), 2);
    chk("example_match_cnt_hold", longint'(match_cnt), 2);

    // empty list A: done one cycle after start, nothing written
    load_rand(0, 5, 2);
    w0 = wr_total;
    start_merge(0, 5);
    chk("empty_done_latency", longint'(done), 1);
    chk("empty_a_addr", longint'(a_addr), 0);
    chk("empty_b_addr", longint'(b_addr), 0);
    wait_done(cyc);
    chk("empty_writes", longint'(wr_total - w0), 0);

    // full FIFO stalls the merge in CMP until the consumer drains it
    repeat (4) @(posedge clk);
    #0;
    ready_mode = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      a_mem[i] = IDX_W'(3 * i + 2);
      b_mem[i] = IDX_W'(3 * i + 2);
    end
    w0 = wr_total;
    start_merge(5, 5);
    repeat (40) @(posedge clk);
    #1;
    chk("stall_writes", longint'(wr_total - w0), 2);
    chk("stall_state", longint'(dbg_state), longint'(ST_CMP));
    chk("stall_busy", longint'(busy), 1);
    ready_mode = 1;
    wait_done(cyc);
    chk("stall_resume_writes", longint'(wr_total - w0), 5);

    // start while busy must be ignored
    ready_mode = 2;
    load_rand(8, 8, 2);
    start_merge(8, 8);
    repeat (3) @(posedge clk);
    #1;
    a_len = '0;
    b_len = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_start_state", longint'(busy), 1);
    wait_done(cyc);

    // asynchronous reset in the middle of a merge
    load_rand(10, 10, 2);
    start_merge(10, 10);
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("midreset");
    exp_q.delete();
    cnt_q.delete();
    occ_m = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    load_rand(9, 7, 2);
    start_merge(9, 7);
    wait_done(cyc);

    // randomized merges
    for (int t = 0; t < 30; t++) begin
      ready_mode = (t % 3 == 0) ? 1 : 2;
      alen = $urandom_range(0, 12);
      blen = $urandom_range(0, 12);
      load_rand(alen, blen, $urandom_range(1, 3));
      start_merge(alen, blen);
      if (alen == 0 || blen == 0) chk("rand_empty_latency", longint'(done), 1);
      wait_done(cyc);
    end

    ready_mode = 1;
    repeat (10) @(posedge clk);
    #1;
    chk("final_drain", longint'(occ_m), 0);
    chk("final_queue", longint'(exp_q.size() + cnt_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
